// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write/read strobe sequencer: latches a bus request, then
// walks setup, enable pulse, hold and command execution wait before going idle.
module lcd_ctrl #(
    parameter int SETUP_CYC     = 2,
    parameter int PULSE_CYC     = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_lcd_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        drop_o
);

    localparam int CNT_W = ($clog2(LONG_EXEC_CYC + 1) > 17) ? $clog2(LONG_EXEC_CYC + 1) : 17;

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] L_EXEC  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(LONG_EXEC_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en_d;
    logic             r_arm;

    logic w_req;
    logic w_cnt_zero;
    logic w_long;
    logic w_unused_bits;

    // r_arm stays low until bit 10 has been seen low after reset, so a level
    // already high at reset release is not mistaken for a fresh rising edge.
    assign w_req         = io_lcd_i[10] & ~r_en_d & r_arm;
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_long        = ~lcd_rs_o && (lcd_data_o inside {8'h01, 8'h02, 8'h03});
    assign w_unused_bits = ^io_lcd_i[30:11];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_en_d     <= 1'b0;
            r_arm      <= 1'b0;
            lcd_on_o   <= 1'b0;
            lcd_en_o   <= 1'b0;
            lcd_rs_o   <= 1'b0;
            lcd_rw_o   <= 1'b0;
            lcd_data_o <= '0;
            busy_o     <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            r_en_d   <= io_lcd_i[10];
            r_arm    <= r_arm | ~io_lcd_i[10];
            lcd_on_o <= io_lcd_i[31];
            drop_o   <= w_req && (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        lcd_rs_o   <= io_lcd_i[9];
                        lcd_rw_o   <= io_lcd_i[8];
                        lcd_data_o <= io_lcd_i[7:0];
                        r_cnt      <= L_SETUP;
                        r_state    <= S_SETUP;
                        busy_o     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_zero) begin
                        r_cnt    <= L_PULSE;
                        r_state  <= S_PULSE;
                        lcd_en_o <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (w_cnt_zero) begin
                        r_cnt    <= L_HOLD;
                        r_state  <= S_HOLD;
                        lcd_en_o <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= w_long ? L_LONG : L_EXEC;
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    lcd_en_o <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter SETUP_CYC, default 2: clock cycles from RS/RW/data valid to EN rise (tAS).
REQ-002 Parameter PULSE_CYC, default 12: EN high width in cycles.
REQ-003 Parameter HOLD_CYC, default 2: cycles RS/RW/data held after EN fall.
REQ-004 Parameter EXEC_CYC, default 2000: post-write command execution wait, normal commands.
REQ-005 Parameter LONG_EXEC_CYC, default 82000: post-write wait for clear/home commands.
REQ-006 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_ni  input  1  asynchronous, active-low reset.
REQ-008 io_lcd_i  input  32  core LCD register: [31] ON, [10] EN request, [9] RS, [8] RW, [7:0] data; other bits ignored.
REQ-009 lcd_on_o  output  1  panel power/backlight.
REQ-010 lcd_en_o  output  1  HD44780 E strobe.
REQ-011 lcd_rs_o  output  1  register select.
REQ-012 lcd_rw_o  output  1  read/write select, 0 = write.
REQ-013 lcd_data_o  output  8  data bus.
REQ-014 busy_o  output  1  high while a transfer or execution wait is in progress.
REQ-015 drop_o  output  1  one-cycle pulse when a request is rejected.

Function
REQ-016 Block shall register io_lcd_i[10] each cycle; request = current bit 1 and registered bit 0 (rising edge).
REQ-017 lcd_on_o shall equal io_lcd_i[31] delayed one cycle, independent of FSM state.
REQ-018 FSM states: IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-019 IDLE + request: latch RS, RW, data into output registers; load counter with SETUP_CYC-1; go to SETUP; busy_o high from the next cycle.
REQ-020 SETUP: lcd_en_o 0; at counter 0 load PULSE_CYC-1, go to PULSE.
REQ-021 PULSE: lcd_en_o 1 for exactly PULSE_CYC cycles; at counter 0 load HOLD_CYC-1, go to HOLD.
REQ-022 HOLD: lcd_en_o 0; RS/RW/data unchanged; at counter 0 load wait count, go to EXEC.
REQ-023 Wait count = LONG_EXEC_CYC-1 if latched RS=0 and data in {0x01,0x02,0x03}; else EXEC_CYC-1.
REQ-024 EXEC: at counter 0 go to IDLE; busy_o low in the IDLE cycle.
REQ-025 lcd_rs_o, lcd_rw_o, lcd_data_o shall change only on IDLE request acceptance; they hold the last values between transfers.
REQ-026 Request while not IDLE: ignored, no state change, drop_o = 1 for one cycle.
REQ-027 Request in the same cycle the FSM returns EXEC->IDLE: counts as busy and is dropped.
REQ-028 Counter shall be 17 bits minimum (holds LONG_EXEC_CYC-1); all parameters shall be >= 1; counter decrements by 1 per cycle, no wrap.
REQ-029 Changes to io_lcd_i[9:0] mid-transfer shall not affect the transfer in progress.
REQ-030 Read (RW=1) shall use the same timing; the block shall not sample the data bus.

Reset
REQ-031 rst_ni low shall immediately force: FSM IDLE, counter 0, registered EN bit 0, all outputs 0.
REQ-032 Reset asserted mid-transfer shall abort it; lcd_en_o low asynchronously; no resumption after release.
REQ-033 First request after reset is accepted if io_lcd_i[10] rises after release; bit 10 already high at release gives no request until it goes 0 then 1.

Verification (SETUP=2, PULSE=3, HOLD=2, EXEC=5, LONG=9)
REQ-034 Write io_lcd_i=0x8000_0641 (ON, EN, RS, data 0x41) -> lcd_on_o 1; rs 1, rw 0, data 0x41 after 1 cycle; en high for exactly 3 cycles starting 2 cycles after latch; busy_o high for 12 cycles total.
REQ-035 Write io_lcd_i=0x0000_0401 (clear) -> EXEC phase 9 cycles; busy_o high for 16 cycles.
REQ-036 Second EN rising edge during PULSE -> drop_o one-cycle pulse; outputs and timing of the first transfer unchanged.
REQ-037 Hold io_lcd_i[10]=1 across two transfer durations -> exactly one transfer performed.
REQ-038 rst_ni low during PULSE -> lcd_en_o, busy_o, data 0 in the same cycle; after release, IDLE with no EN activity until a new rising edge.
REQ-039 Request in exact cycle of EXEC->IDLE -> dropped (drop_o=1); next rising edge one cycle later -> accepted.
